// File: rtl/synapse_accum_q14.sv
// Spike-gated synaptic current accumulator: sums Q1.14 weights per neuron.
// Define SYNAPSE_ACCUM_SKIP_ZERO_EN to issue reads only for active inputs.
module synapse_accum_q14 #(
  parameter int F = 48,
  parameter int N = 96,
  parameter int Q = 14,
  localparam int AW = $clog2(F * N),
  localparam int NW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [F-1:0]  pre_bits,
  output logic          w_re,
  output logic [AW-1:0] w_addr,
  input  logic [15:0]   w_rdata,
  output logic          cur_valid,
  input  logic          cur_ready,
  output logic [NW-1:0] cur_idx,
  output logic [31:0]   cur_q14,
  output logic          busy,
  output logic          done
);

  localparam int FW = (F > 1) ? $clog2(F) : 1;
  localparam int WW = Q + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [F-1:0]  pre_q, pre_d;
  logic [31:0]   acc_q, acc_d;
  logic          add_q, add_d;
  logic [FW-1:0] f_cur;
  logic [31:0]   w_ext;

  assign w_ext = {{(32 - WW){w_rdata[WW-1]}}, w_rdata[WW-1:0]};

`ifdef SYNAPSE_ACCUM_SKIP_ZERO_EN
  logic [F-1:0] mask_q, mask_d;

  // Lowest set bit of the remaining mask gives ascending read order.
  function automatic logic [FW-1:0] ffs(input logic [F-1:0] m);
    ffs = '0;
    for (int i = F - 1; i >= 0; i--)
      if (m[i]) ffs = FW'(i);
  endfunction

  assign f_cur = ffs(mask_q);
`else
  logic [FW-1:0] f_q, f_d;

  assign f_cur = f_q;
`endif

  assign w_addr = AW'(f_cur) * AW'(N) + AW'(n_q);
  assign cur_valid = (state_q == S_OUT);
  assign cur_idx = n_q;
  assign cur_q14 = acc_q;
  assign done = (state_q == S_DONE);
  assign busy = (state_q == S_READ) ||
                (state_q == S_DRAIN) ||
                (state_q == S_OUT);

  always_comb begin
    state_d = state_q;
    n_d = n_q;
    pre_d = pre_q;
    acc_d = acc_q;
    w_re = 1'b0;
`ifdef SYNAPSE_ACCUM_SKIP_ZERO_EN
    mask_d = mask_q;
`else
    f_d = f_q;
`endif
    // Data for the read issued last cycle lands now.
    if (add_q) acc_d = acc_q + w_ext;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pre_d = pre_bits;
          acc_d = '0;
          n_d = '0;
`ifdef SYNAPSE_ACCUM_SKIP_ZERO_EN
          mask_d = pre_bits;
          state_d = (|pre_bits) ? S_READ : S_DRAIN;
`else
          f_d = '0;
          state_d = S_READ;
`endif
        end
      end
      S_READ: begin
        w_re = 1'b1;
`ifdef SYNAPSE_ACCUM_SKIP_ZERO_EN
        mask_d = mask_q & (mask_q - F'(1));
        if (mask_d == '0) state_d = S_DRAIN;
`else
        if (f_q == FW'(F - 1)) begin
          f_d = '0;
          state_d = S_DRAIN;
        end else begin
          f_d = f_q + FW'(1);
        end
`endif
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        if (cur_ready) begin
          if (n_q == NW'(N - 1)) begin
            state_d = S_DONE;
          end else begin
            n_d = n_q + NW'(1);
            acc_d = '0;
`ifdef SYNAPSE_ACCUM_SKIP_ZERO_EN
            mask_d = pre_q;
            state_d = (|pre_q) ? S_READ : S_DRAIN;
`else
            f_d = '0;
            state_d = S_READ;
`endif
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    add_d = w_re & pre_q[f_cur];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q <= '0;
      pre_q <= '0;
      acc_q <= '0;
      add_q <= 1'b0;
`ifdef SYNAPSE_ACCUM_SKIP_ZERO_EN
      mask_q <= '0;
`else
      f_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      pre_q <= pre_d;
      acc_q <= acc_d;
      add_q <= add_d;
`ifdef SYNAPSE_ACCUM_SKIP_ZERO_EN
      mask_q <= mask_d;
`else
      f_q <= f_d;
`endif
    end
  end

endmodule

// File: tb/tb_synapse_accum_q14.sv
// Scoreboard bench for synapse_accum_q14 with F=4, N=3.
module tb_synapse_accum_q14;

  localparam int F = 4;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  pre_bits = '0;
  logic        w_re;
  logic [3:0]  w_addr;
  logic [15:0] w_rdata = '0;
  logic        cur_valid;
  logic        cur_ready = 1'b1;
  logic [1:0]  cur_idx;
  logic [31:0] cur_q14;
  logic        busy;
  logic        done;

  synapse_accum_q14 #(.F(F), .N(N), .Q(14)) dut (
    .clk(clk), .rst(rst), .start(start), .pre_bits(pre_bits),
    .w_re(w_re), .w_addr(w_addr), .w_rdata(w_rdata),
    .cur_valid(cur_valid), .cur_ready(cur_ready),
    .cur_idx(cur_idx), .cur_q14(cur_q14),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic signed [15:0] mem [16];

  always @(posedge clk)
    if (w_re) w_rdata <= mem[w_addr];

  typedef struct { int idx; int val; } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int rd_sum = 0;

  task automatic chk(input string nm, input longint act, input longint want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (w_re) begin
        rd_cnt++;
        rd_sum += int'(w_addr);
      end
      if (cur_valid && cur_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", longint'(cur_idx), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cur_idx", longint'(cur_idx), e.idx);
          chk("cur_q14", longint'($signed(cur_q14)), e.val);
        end
      end
    end
  end

  task automatic push(input int i, input int v);
    exp_q.push_back('{i, v});
  endtask

  task automatic mem_ramp();
    for (int a = 0; a < 16; a++) mem[a] = 16'(a + 1) * 16'sd1024;
  endtask

  task automatic start_pass(input logic [3:0] p);
    @(posedge clk);
    #1 pre_bits = p;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_done"}, done_cnt - d0, 1);
    chk({nm, "_idle"}, longint'(busy), 0);
  endtask

  task automatic wait_valid(input string nm);
    int k;
    k = 0;
    while (!cur_valid && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    chk({nm, "_valid"}, longint'(cur_valid), 1);
  endtask

  initial begin
    int k;
    mem_ramp();
    #3;
    chk("rst_w_re", w_re, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_valid", cur_valid, 0);
    chk("rst_q14", cur_q14, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // n0: W[0]+W[6]; n1: W[1]+W[7]; n2: W[2]+W[8]
    push(0, (1 + 7) * 1024);
    push(1, (2 + 8) * 1024);
    push(2, (3 + 9) * 1024);
    rd_cnt = 0;
    start_pass(4'b0101);
    chk("busy_after_start", busy, 1);
    k = 1;
    while (!cur_valid && k < 50) begin
      @(posedge clk);
      #1 k++;
    end
`ifdef SYNAPSE_ACCUM_SKIP_ZERO_EN
    chk("first_valid_latency", k, 4);
`else
    chk("first_valid_latency", k, 6);
`endif
    wait_done("p0101");
`ifdef SYNAPSE_ACCUM_SKIP_ZERO_EN
    chk("reads_0101", rd_cnt, 6);
`else
    chk("reads_0101", rd_cnt, 12);
`endif

    push(0, 0);
    push(1, 0);
    push(2, 0);
    start_pass(4'b0000);
    wait_done("p0000");

    for (int a = 0; a < 16; a++) mem[a] = 16'sh8000;
    mem[0] = -16'sd16384;
    push(0, -16384);
    push(1, -32768);
    push(2, -32768);
    start_pass(4'b0001);
    wait_done("neg0001");
    mem[0] = 16'sh8000;
    push(0, -131072);
    push(1, -131072);
    push(2, -131072);
    start_pass(4'b1111);
    wait_done("neg1111");

    mem_ramp();
    rd_cnt = 0;
    rd_sum = 0;
    push(0, (4 + 10) * 1024);
    push(1, (5 + 11) * 1024);
    push(2, (6 + 12) * 1024);
    start_pass(4'b1010);
    wait_done("p1010");
`ifdef SYNAPSE_ACCUM_SKIP_ZERO_EN
    chk("reads_1010", rd_cnt, 6);
    chk("addr_sum_1010", rd_sum, 3 + 9 + 4 + 10 + 5 + 11);
`else
    chk("reads_1010", rd_cnt, 12);
    chk("addr_sum_1010", rd_sum, 66);
`endif

    cur_ready = 1'b0;
    push(0, (1 + 7) * 1024);
    push(1, (2 + 8) * 1024);
    push(2, (3 + 9) * 1024);
    start_pass(4'b0101);
    wait_valid("bp_n0");
    cur_ready = 1'b1;
    @(posedge clk);
    #1 cur_ready = 1'b0;
    wait_valid("bp_n1");
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", cur_valid, 1);
      chk("bp_idx", cur_idx, 1);
      chk("bp_q14", cur_q14, (2 + 8) * 1024);
      start = (i % 2 == 0);
      pre_bits = 4'b1111;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("bp_no_reads", rd_cnt, 0);
    cur_ready = 1'b1;
    wait_done("bp");

    push(0, (1 + 7) * 1024);
    start_pass(4'b0101);
    k = 0;
    while (!(w_re && w_addr == 4'd1) && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    chk("rst_reached_n1", longint'(w_re && w_addr == 4'd1), 1);
    k = done_cnt;
    rst = 1'b1;
    #1;
    chk("mid_rst_w_re", w_re, 0);
    chk("mid_rst_w_addr", w_addr, 0);
    chk("mid_rst_valid", cur_valid, 0);
    chk("mid_rst_idx", cur_idx, 0);
    chk("mid_rst_q14", cur_q14, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_cnt - k, 0);

    push(0, 10 * 1024);
    push(1, 11 * 1024);
    push(2, 12 * 1024);
    start_pass(4'b1000);
    wait_done("restart");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
